// File: rtl/bird_column_driver.sv
// Single-column flappy-bird core: one-hot bird height with flap/gravity,
// sticky collision against green tube pixels, and row scan onto the LED bus.
module bird_column_driver #(
    parameter int unsigned FALL_DIV  = 4096,
    parameter int unsigned BIRD_LINE = 11,
    parameter int unsigned START_POS = 9
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         key,
    input  logic         enable_count,
    input  logic [255:0] grn_pixels,
    output logic [15:0]  bird_pos,
    output logic         dead,
    output logic [35:0]  gpio
);

    localparam logic [15:0] START_ONEHOT = 16'(1) << START_POS;
    localparam logic [15:0] FALL_LAST    = 16'(FALL_DIV - 1);

    logic [15:0] pos_reg, pos_next;
    logic [15:0] grav_reg, grav_next;
    logic        dead_reg, dead_next;
    logic        key_q_reg;
    logic [3:0]  row_reg, row_next;

    logic        flap;
    logic        fall;
    logic        hit;
    logic [15:0] bird_line;
    logic [15:0] grn_line [16];

    // Split the flat frame into addressable lines for the scan mux.
    for (genvar gi = 0; gi < 16; gi++) begin : g_lines
        assign grn_line[gi] = grn_pixels[gi*16 +: 16];
    end

    assign bird_line = grn_line[BIRD_LINE[3:0]];
    assign flap      = key & ~key_q_reg;
    assign fall      = (grav_reg == FALL_LAST);
    assign hit       = |(pos_reg & bird_line);

    always_comb begin
        pos_next  = pos_reg;
        grav_next = grav_reg;
        dead_next = dead_reg | hit;
        row_next  = row_reg;

        // A frozen bird keeps both its height and its gravity phase.
        if (!dead_reg) begin
            if (flap) begin
                grav_next = '0;
                if (!pos_reg[15]) begin
                    pos_next = pos_reg << 1;
                end
            end else if (fall) begin
                grav_next = '0;
                if (!pos_reg[0]) begin
                    pos_next = pos_reg >> 1;
                end
            end else begin
                grav_next = grav_reg + 16'd1;
            end
        end

        if (enable_count) begin
            row_next = row_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            pos_reg   <= START_ONEHOT;
            grav_reg  <= '0;
            dead_reg  <= 1'b0;
            key_q_reg <= 1'b0;
            row_reg   <= '0;
        end else begin
            pos_reg   <= pos_next;
            grav_reg  <= grav_next;
            dead_reg  <= dead_next;
            key_q_reg <= key;
            row_reg   <= row_next;
        end
    end

    assign bird_pos     = pos_reg;
    assign dead         = dead_reg;
    assign gpio[15:0]   = (row_reg == BIRD_LINE[3:0]) ? pos_reg : 16'h0000;
    assign gpio[31:16]  = grn_line[row_reg];
    assign gpio[35:32]  = row_reg;

endmodule

// File: tb/tb_bird_column_driver.sv
// Randomised and directed bench for bird_column_driver against an integer-height model.
module tb_bird_column_driver;

    localparam int FD   = 4;
    localparam int LINE = 11;

    logic         clk = 1'b0;
    logic         RST = 1'b0;
    logic         key = 1'b0;
    logic         enable_count = 1'b0;
    logic [255:0] grn_pixels = '0;
    logic [15:0]  bird_pos;
    logic         dead;
    logic [35:0]  gpio;

    int n_checks = 0;
    int n_fails  = 0;
    bit cmp_en   = 1'b0;

    // Model state: plain integers for height, gravity phase and scan row.
    int m_h    = 9;
    int m_cnt  = 0;
    bit m_dead = 1'b0;
    bit m_kq   = 1'b0;
    int m_row  = 0;

    bird_column_driver #(.FALL_DIV(FD), .BIRD_LINE(LINE), .START_POS(9)) dut (
        .clk(clk), .RST(RST), .key(key), .enable_count(enable_count),
        .grn_pixels(grn_pixels), .bird_pos(bird_pos), .dead(dead), .gpio(gpio)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            m_h = 9; m_cnt = 0; m_dead = 0; m_kq = 0; m_row = 0;
        end else begin
            bit flap;
            bit hit;
            flap = key && !m_kq;
            hit  = grn_pixels[LINE*16 + m_h];
            if (!m_dead) begin
                if (flap) begin
                    if (m_h < 15) m_h++;
                    m_cnt = 0;
                end else if (m_cnt == FD - 1) begin
                    if (m_h > 0) m_h--;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (hit) m_dead = 1;
            m_kq = key;
            if (enable_count) m_row = (m_row + 1) % 16;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [15:0] red;
            logic [15:0] exp_pos;
            exp_pos = 16'(1) << m_h;
            red = (m_row == LINE) ? exp_pos : 16'h0;
            check("bird_pos", {20'h0, bird_pos}, {20'h0, exp_pos});
            check("dead", {35'h0, dead}, {35'h0, m_dead});
            check("gpio", gpio, {4'(m_row), grn_pixels[m_row*16 +: 16], red});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        key = 1'b0;
        enable_count = 1'b0;
        tick(2);
        RST = 1'b1;
    endtask

    initial begin
        do_reset();
        cmp_en = 1'b1;
        check("reset_pos", {20'h0, bird_pos}, 36'h0200);
        check("reset_dead", {35'h0, dead}, 36'h0);
        check("reset_row", {32'h0, gpio[35:32]}, 36'h0);

        // Idle fall and bottom saturation.
        tick(4); check("fall4", {20'h0, bird_pos}, 36'h0100);
        tick(4); check("fall8", {20'h0, bird_pos}, 36'h0080);
        tick(60); check("bottom", {20'h0, bird_pos}, 36'h0001);

        // Held key: single flap, gravity restarts.
        do_reset();
        key = 1'b1;
        tick(1); check("flap_up", {20'h0, bird_pos}, 36'h0400);
        tick(3); check("held_nofall", {20'h0, bird_pos}, 36'h0400);
        tick(1); check("held_fall", {20'h0, bird_pos}, 36'h0200);
        tick(5); key = 1'b0;
        tick(1);

        // Flap coincident with the fall cycle wins.
        do_reset();
        tick(3);
        key = 1'b1;
        tick(1); check("flap_wins", {20'h0, bird_pos}, 36'h0400);
        key = 1'b0;

        // Top saturation via repeated presses.
        do_reset();
        repeat (9) begin
            key = 1'b1; tick(1);
            key = 1'b0; tick(1);
        end
        check("top_sat", {20'h0, bird_pos}, 36'h8000);

        // Collision with a tube pixel, then freeze.
        grn_pixels = '0;
        grn_pixels[LINE*16 +: 16] = 16'h0100;
        do_reset();
        tick(4); check("on_tube", {20'h0, bird_pos}, 36'h0100);
        check("not_dead_yet", {35'h0, dead}, 36'h0);
        tick(1); check("dead_set", {35'h0, dead}, 36'h1);
        repeat (5) begin
            key = 1'b1; tick(1);
            key = 1'b0; tick(2);
        end
        check("frozen", {20'h0, bird_pos}, 36'h0100);

        // Scan while dead, then async reset mid-row.
        enable_count = 1'b1;
        tick(16); check("row_wrap", {32'h0, gpio[35:32]}, 36'h0);
        tick(7);
        enable_count = 1'b0;
        check("row7", {32'h0, gpio[35:32]}, 36'h7);
        #1 RST = 1'b0;
        #1;
        check("async_pos", {20'h0, bird_pos}, 36'h0200);
        check("async_dead", {35'h0, dead}, 36'h0);
        check("async_row", {32'h0, gpio[35:32]}, 36'h0);
        tick(1);
        RST = 1'b1;
        grn_pixels = '0;

        // Randomised episodes.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                key = ($urandom_range(0, 2) == 0);
                enable_count = $urandom_range(0, 1);
                for (int w = 0; w < 8; w++) grn_pixels[w*32 +: 32] = $urandom;
                grn_pixels[LINE*16 +: 16] = '0;
                if ($urandom_range(0, 25) == 0)
                    grn_pixels[LINE*16 + $urandom_range(0, 15)] = 1'b1;
                tick(1);
            end
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/bird_column_driver.md
Name: bird_column_driver

Overview:
- Single-column flappy-bird core for the 16x16 red/green LED matrix.
- Holds the bird's one-hot height, applies flap (rising edge of key) and periodic gravity, and detects collision with green tube pixels (sticky dead flag).
- Row-scans the combined red/green frame onto a 36-bit GPIO bus.
- Sits between the user-input/tube logic and the board LED connector.

Parameters:
- FALL_DIV, 4096, clk cycles per gravity step; legal range 2..65535.
- BIRD_LINE, 11, matrix line (0..15) in which the bird is drawn and collisions are checked.
- START_POS, 9, bird height after reset (0 = bottom, 15 = top).

Ports:
- clk  in  1  system clock, all state on rising edge.
- RST  in  1  reset; asynchronous, active-low.
- key  in  1  flap button level, 1 = pressed; may be held for many cycles.
- enable_count  in  1  scan-advance enable.
- grn_pixels  in  256  green frame; bit i*16+j = line i, position j.
- bird_pos  out  16  one-hot bird height, bit 15 = top.
- dead  out  1  sticky collision flag.
- gpio  out  36  LED scan bus.

Behaviour:
- Reset (RST=0, async):
  - bird_pos = 1<<START_POS (default 16'h0200).
  - dead = 0, scan_row = 0.
  - grav_cnt = 0, key_q = 0.
- Flap detect:
  - key_q <= key every cycle.
  - flap = key & ~key_q, exactly one cycle per press.
  - Holding key gives no further flaps; release then press again for the next one.
- Gravity counter:
  - When dead=0, grav_cnt increments by 1 each cycle.
  - fall = (grav_cnt == FALL_DIV-1); on that cycle grav_cnt wraps to 0.
  - On a flap cycle grav_cnt is cleared to 0 and fall is ignored.
- Position update per edge, in priority order:
  - dead=1: hold.
  - else flap: shift up one (pos+1), saturating at bit 15.
  - else fall: shift down one (pos-1), saturating at bit 0.
  - else hold.
  - Exactly one bit set at all times. Bottom (pos 0) is not lethal; the bird rests there.
- Collision:
  - hit = |(bird_pos & grn_pixels[BIRD_LINE*16 +: 16]), combinational on current state.
  - dead <= 1 on the first edge where hit=1; stays 1 until reset.
  - A flap or fall landing on a green bit sets dead on the following edge.
  - Once dead, bird_pos and grav_cnt freeze.
- Scan:
  - scan_row (4 bit) increments on edges where enable_count=1 and wraps 15->0.
  - Scanning continues while dead.
- gpio, combinational from registered state and inputs:
  - [15:0] red line: bird_pos if scan_row==BIRD_LINE, else 0.
  - [31:16] green line: grn_pixels[scan_row*16 +: 16].
  - [35:32] scan_row.
- LED polarity is active-high throughout.
- No X on outputs after reset; unused gpio bits: none.

Test Plan:
- Reset then idle, key=0, grn=0, FALL_DIV=4 -> bird_pos 16'h0200, then 16'h0100 after 4 cycles, 16'h0080 after 8; saturates at 16'h0001 and stays.
- Press key for 10 cycles from 16'h0200 -> one step to 16'h0400 only; grav_cnt restarts, so the next fall comes 4 cycles after the flap.
- Flap on the same cycle grav_cnt==FALL_DIV-1 -> moves up (flap wins); repeated presses from 16'h4000 -> 16'h8000 then holds at 16'h8000.
- grn line 11 = 16'h0100, bird falls from 16'h0200 -> dead=1 one edge after bird_pos=16'h0100; later keys and falls leave bird_pos unchanged.
- enable_count=1 for 17 cycles -> gpio[35:32] runs 0..15 then 0. gpio[15:0]=bird_pos only at row 11. gpio[31:16] equals the matching grn line.
- Assert RST low mid-game with dead=1 and scan_row=7 -> immediately bird_pos=16'h0200, dead=0, gpio[35:32]=0.
